// File: rtl/risc_pkg.sv
// Shared datapath constants: default widths, IR field positions and small helpers.
// Used by reg_select_file and reg_select_decode.
package risc_pkg;

   localparam int RISC_DATA_W   = 32;
   localparam int RISC_NUM_REGS = 16;
   localparam int RISC_IDX_W    = 4;
   localparam int RISC_IMM_W    = 19;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 27;
   localparam int RA_MSB  = 26;
   localparam int RA_LSB  = 23;
   localparam int RB_MSB  = 22;
   localparam int RB_LSB  = 19;
   localparam int RC_MSB  = 18;
   localparam int RC_LSB  = 15;

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_REG,
      SRC_BASE,
      SRC_CONST
   } bus_src_e;

   // True when two or more of three strobes are raised together.
   function automatic logic more_than_one(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/reg_select_decode.sv
// Register-select decoder: picks ra/rb/rc by Gra>Grb>Grc priority and flags
// multiple simultaneous selects.
module reg_select_decode
   import risc_pkg::*;
#(
   parameter int IDX_W = RISC_IDX_W
) (
   input  logic [IDX_W-1:0] ra,
   input  logic [IDX_W-1:0] rb,
   input  logic [IDX_W-1:0] rc,
   input  logic             gra,
   input  logic             grb,
   input  logic             grc,
   output logic [IDX_W-1:0] sel_idx,
   output logic             sel_valid,
   output logic             sel_multi
);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      sel_idx   = '0;
      sel_valid = 1'b0;
      if (gra) begin
         sel_idx   = ra;
         sel_valid = 1'b1;
      end else if (grb) begin
         sel_idx   = rb;
         sel_valid = 1'b1;
      end else if (grc) begin
         sel_idx   = rc;
         sel_valid = 1'b1;
      end
   end

   assign sel_multi = more_than_one(gra, grb, grc);

endmodule

// File: rtl/reg_select_file.sv
// General register file with IR, field select, C-constant extension and bus driver.
// Optional `RF_R0_HARDWIRED_EN: R0 reads as 0 and ignores writes.
module reg_select_file
   import risc_pkg::*;
#(
   parameter int DATA_W   = RISC_DATA_W,
   parameter int NUM_REGS = RISC_NUM_REGS,
   parameter int IDX_W    = RISC_IDX_W,
   parameter int IMM_W    = RISC_IMM_W
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Clear,
   input  logic              Run,
   input  logic              IRin,
   input  logic [DATA_W-1:0] BusMuxOut,
   input  logic              Gra,
   input  logic              Grb,
   input  logic              Grc,
   input  logic              Rin,
   input  logic              Rout,
   input  logic              BAout,
   input  logic              Cout,
   output logic [DATA_W-1:0] BusMuxIn,
   output logic              bus_drive,
   output logic [DATA_W-1:0] IR,
   output logic [4:0]        opcode,
   output logic [DATA_W-1:0] C_sign_extended,
   output logic [IDX_W-1:0]  sel_idx,
   output logic              sel_err
);

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic              sel_valid;
   logic              sel_multi;
   logic              err_set;
   logic              wr_en;
   logic              idx_zero;
   logic [DATA_W-1:0] reg_val;
   bus_src_e          bus_src;

   reg_select_decode #(.IDX_W(IDX_W)) u_decode (
      .ra        (IR[RA_MSB:RA_LSB]),
      .rb        (IR[RB_MSB:RB_LSB]),
      .rc        (IR[RC_MSB:RC_LSB]),
      .gra       (Gra),
      .grb       (Grb),
      .grc       (Grc),
      .sel_idx   (sel_idx),
      .sel_valid (sel_valid),
      .sel_multi (sel_multi)
   );

   assign opcode          = IR[OPC_MSB:OPC_LSB];
   assign C_sign_extended = {{(DATA_W-IMM_W){IR[IMM_W-1]}}, IR[IMM_W-1:0]};
   assign idx_zero        = (sel_idx == '0);

   assign err_set = sel_multi | more_than_one(Rout, BAout, Cout)
                  | ((Rin | Rout | BAout) & ~sel_valid);

`ifdef RF_R0_HARDWIRED_EN
   assign wr_en   = Run & Rin & sel_valid & ~idx_zero;
   assign reg_val = idx_zero ? '0 : regs[sel_idx];
`else
   assign wr_en   = Run & Rin & sel_valid;
   assign reg_val = regs[sel_idx];
`endif

   always_ff @(posedge Clock) begin
      if (Reset || Clear) begin
         // NOTE: the whole array is cleared because software relies on zeroed registers after Reset/Clear.
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         IR      <= '0;
         sel_err <= 1'b0;
      end else begin
         // NOTE: non-blocking so reads this cycle see the old value and Rin uses the old IR fields.
         if (err_set)     sel_err       <= 1'b1;
         if (wr_en)       regs[sel_idx] <= BusMuxOut;
         if (Run && IRin) IR            <= BusMuxOut;
      end
   end

   always_comb begin
      bus_src = SRC_NONE;
      if (Rout)       bus_src = SRC_REG;
      else if (BAout) bus_src = SRC_BASE;
      else if (Cout)  bus_src = SRC_CONST;
   end

   always_comb begin
      BusMuxIn = '0;
      unique case (bus_src)
         SRC_REG:   BusMuxIn = reg_val;
         SRC_BASE:  BusMuxIn = idx_zero ? '0 : reg_val;
         SRC_CONST: BusMuxIn = C_sign_extended;
         default:   BusMuxIn = '0;
      endcase
   end

   assign bus_drive = Rout | BAout | Cout;

endmodule

// File: tb/tb_reg_select_file.sv
// Self-checking bench for reg_select_file: directed scenarios then random steps
// against a behavioural model. Honors `RF_R0_HARDWIRED_EN like the DUT.
module tb_reg_select_file;

   logic        Clock = 1'b0;
   logic        Reset, Clear, Run, IRin;
   logic [31:0] BusMuxOut;
   logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout;
   logic [31:0] BusMuxIn, IR, C_sign_extended;
   logic        bus_drive, sel_err;
   logic [4:0]  opcode;
   logic [3:0]  sel_idx;

   int n_cmp = 0;
   int n_bad = 0;

   // behavioural model state
   logic [31:0] m_regs [16];
   logic [31:0] m_ir;
   logic        m_err;

`ifdef RF_R0_HARDWIRED_EN
   localparam bit R0_HW = 1'b1;
`else
   localparam bit R0_HW = 1'b0;
`endif

   reg_select_file dut (
      .Clock(Clock), .Reset(Reset), .Clear(Clear), .Run(Run), .IRin(IRin),
      .BusMuxOut(BusMuxOut), .Gra(Gra), .Grb(Grb), .Grc(Grc),
      .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
      .BusMuxIn(BusMuxIn), .bus_drive(bus_drive), .IR(IR), .opcode(opcode),
      .C_sign_extended(C_sign_extended), .sel_idx(sel_idx), .sel_err(sel_err)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
      end
   endtask

   // Model: what the spec says the outputs are, given the current strobes and stored state.
   task automatic check_outputs();
      int          idx;
      int          n_sel, n_drv;
      logic [31:0] cval, exp_bus;
      n_sel = int'(Gra) + int'(Grb) + int'(Grc);
      n_drv = int'(Rout) + int'(BAout) + int'(Cout);
      idx   = Gra ? int'(m_ir[26:23]) : Grb ? int'(m_ir[22:19]) : Grc ? int'(m_ir[18:15]) : 0;
      cval  = m_ir[18] ? (m_ir & 32'h0007_FFFF) | 32'hFFF8_0000 : m_ir & 32'h0007_FFFF;
      if (Rout)       exp_bus = (R0_HW && idx == 0) ? 32'h0 : m_regs[idx];
      else if (BAout) exp_bus = (idx == 0) ? 32'h0 : m_regs[idx];
      else if (Cout)  exp_bus = cval;
      else            exp_bus = 32'h0;
      check("BusMuxIn", BusMuxIn, exp_bus);
      check("bus_drive", {31'd0, bus_drive}, {31'd0, n_drv > 0});
      check("IR", IR, m_ir);
      check("opcode", {27'd0, opcode}, m_ir >> 27);
      check("C_sign_extended", C_sign_extended, cval);
      check("sel_idx", {28'd0, sel_idx}, idx);
      check("sel_err", {31'd0, sel_err}, {31'd0, m_err});
      if (n_sel == 0 && (Rin || Rout || BAout)) n_sel = 2; // no-select use counts as an error below
      if (Reset || Clear) begin
         foreach (m_regs[i]) m_regs[i] = 32'h0;
         m_ir  = 32'h0;
         m_err = 1'b0;
      end else begin
         if (n_sel > 1 || n_drv > 1) m_err = 1'b1;
         if (Run && Rin && (Gra || Grb || Grc) && !(R0_HW && idx == 0)) m_regs[idx] = BusMuxOut;
         if (Run && IRin) m_ir = BusMuxOut;
      end
   endtask

   // One clock step: apply strobes, check combinational outputs mid-cycle, then clock the model.
   task automatic step(input logic rst, input logic clr, input logic run, input logic irin,
                       input logic [31:0] bus, input logic [2:0] g, input logic rin,
                       input logic [2:0] drv);
      Reset = rst; Clear = clr; Run = run; IRin = irin; BusMuxOut = bus;
      {Gra, Grb, Grc} = g; Rin = rin; {Rout, BAout, Cout} = drv;
      #2;
      check_outputs();
      @(posedge Clock);
      #1;
   endtask

   initial begin
      foreach (m_regs[i]) m_regs[i] = 32'h0;
      m_ir = 32'h0; m_err = 1'b0;
      Reset = 1'b1; Clear = 1'b0; Run = 1'b0; IRin = 1'b0; BusMuxOut = '0;
      {Gra, Grb, Grc} = '0; Rin = 1'b0; {Rout, BAout, Cout} = '0;
      @(posedge Clock); #1;
      step(1, 0, 0, 0, 32'h0, 3'b000, 0, 3'b000);

      // 1: IR load, opcode=1, ra=4
      step(0, 0, 1, 1, 32'h0A00_0000, 3'b000, 0, 3'b000);
      check("t1_ir", IR, 32'h0A00_0000);
      check("t1_opcode", {27'd0, opcode}, 32'd1);
      // 2: write ra, read back next cycle
      step(0, 0, 1, 0, 32'hDEAD_BEEF, 3'b100, 1, 3'b000);
      step(0, 0, 1, 0, 32'h0, 3'b100, 0, 3'b100);
      step(0, 0, 1, 0, 32'h0, 3'b100, 0, 3'b100); // sampled again after check_outputs cycle
      // 3: rb=0 base vs register read
      step(0, 0, 1, 0, 32'h0000_1234, 3'b010, 1, 3'b000);
      Gra = 0; Grb = 1; Grc = 0; Rin = 0; Rout = 0; BAout = 1; Cout = 0; #2;
      check("t3_baout_r0", BusMuxIn, 32'h0);
      Rout = 1; BAout = 0; #2;
      check("t3_rout_r0", BusMuxIn, R0_HW ? 32'h0 : 32'h0000_1234);
      step(0, 0, 1, 0, 32'h0, 3'b010, 0, 3'b100);
      // 4: C constant sign extension
      step(0, 0, 1, 1, 32'h0004_0000, 3'b000, 0, 3'b000);
      step(0, 0, 1, 0, 32'h0, 3'b000, 0, 3'b001);
      check("t4_c_neg", C_sign_extended, 32'hFFFC_0000);
      step(0, 0, 1, 1, 32'h0000_0005, 3'b000, 0, 3'b000);
      step(0, 0, 1, 0, 32'h0, 3'b000, 0, 3'b001);
      check("t4_c_pos", BusMuxIn, 32'h0000_0005);
      // 5: double select -> write into ra, sticky error, then Clear
      step(0, 0, 1, 1, 32'h0A00_0000, 3'b000, 0, 3'b000);
      step(0, 0, 1, 0, 32'h5555_AAAA, 3'b110, 1, 3'b000);
      step(0, 0, 1, 0, 32'h0, 3'b100, 0, 3'b100);
      check("t5_err_sticky", {31'd0, sel_err}, 32'd1);
      step(0, 1, 1, 1, 32'hFFFF_FFFF, 3'b100, 1, 3'b000);
      check("t5_clear_err", {31'd0, sel_err}, 32'd0);
      check("t5_clear_ir", IR, 32'h0);
      // 6: Run=0 blocks writes and IR loads, reads still work
      step(0, 0, 1, 1, 32'h0A00_0000, 3'b000, 0, 3'b000);
      step(0, 0, 1, 0, 32'h1111_2222, 3'b100, 1, 3'b000);
      step(0, 0, 0, 1, 32'h9999_9999, 3'b100, 1, 3'b000);
      step(0, 0, 0, 0, 32'h0, 3'b100, 0, 3'b100);
      check("t6_hold", BusMuxIn, 32'h1111_2222);

      // random phase
      for (int n = 0; n < 400; n++) begin
         logic [31:0] bus;
         logic [2:0]  g, d;
         bus = $urandom();
         if ($urandom_range(0, 1) == 0) bus[31:15] = 17'($urandom_range(0, 255)) << 9;
         g = ($urandom_range(0, 7) == 0) ? 3'($urandom()) : 3'b100 >> $urandom_range(0, 3);
         d = ($urandom_range(0, 7) == 0) ? 3'($urandom()) : 3'b100 >> $urandom_range(0, 3);
         step($urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0,
              $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
              bus, g, $urandom_range(0, 1) == 1, d);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
